// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier family: FSM states,
// default operand width and the iteration-counter width helper.
package mult_pkg;

  // Same default as the fixed-width combinational multipliers.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter has to hold WIDTH itself, not just WIDTH-1.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_abs_neg.sv
// Conditional two's-complement negate. It produces operand magnitudes on
// input and the signed result at completion.
module mult_abs_neg #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  // The most negative value maps to itself. Read as unsigned, that is its magnitude.
  assign result_o = negate_i ? ((~value_i) + WIDTH'(1)) : value_i;

endmodule

// File: rtl/multiplier_nbits_seq.sv
// Iterative shift-add multiplier with a valid/ready handshake on both sides.
// Sign is handled as a magnitude product plus a final conditional negate.
module multiplier_nbits_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cntWidth(WIDTH);

  state_e             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;
  logic               inReady_q;
  logic               outValid_q;
  logic               busy_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] result_d;

  mult_abs_neg #(.WIDTH(WIDTH)) uAbsA (
    .value_i  (A),
    .negate_i (is_signed & A[WIDTH-1]),
    .result_o (absA)
  );

  mult_abs_neg #(.WIDTH(WIDTH)) uAbsB (
    .value_i  (B),
    .negate_i (is_signed & B[WIDTH-1]),
    .result_o (absB)
  );

  // mcand_q is pre-shifted each cycle, so it already equals mcand << (WIDTH-cnt).
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  mult_abs_neg #(.WIDTH(2*WIDTH)) uNegResult (
    .value_i  (acc_d),
    .negate_i (neg_q),
    .result_o (result_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      product_q  <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q   <= {{WIDTH{1'b0}}, absA};
            mplier_q  <= absB;
            neg_q     <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            acc_q     <= '0;
            cnt_q     <= CW'(WIDTH);
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          // Fixed WIDTH iterations with no early exit, so latency never depends on the data.
          if (cnt_q == CW'(1)) begin
            product_q  <= result_d;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b1;
          outValid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign product   = product_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multiplier_nbits_seq.sv
// Directed bench for the sequential multiplier at WIDTH=8 and WIDTH=16:
// a vector table plus hand sequences for backpressure and mid-run reset.
module tb_multiplier_nbits_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        inValid8 = 1'b0, inReady8, sgn8 = 1'b0, outValid8, outReady8 = 1'b1, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;

  logic        inValid16 = 1'b0, inReady16, sgn16 = 1'b0, outValid16, outReady16 = 1'b1, busy16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] prod16;

  int vectors = 0;
  int miscompares = 0;

  multiplier_nbits_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
    .A(a8), .B(b8), .is_signed(sgn8), .out_valid(outValid8),
    .out_ready(outReady8), .product(prod8), .busy(busy8)
  );

  multiplier_nbits_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16),
    .A(a16), .B(b16), .is_signed(sgn16), .out_valid(outValid16),
    .out_ready(outReady16), .product(prod16), .busy(busy16)
  );

  typedef struct {
    logic        wide;
    logic [31:0] a;
    logic [31:0] b;
    logic        isSigned;
    logic [31:0] expected;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one operand pair, and checks the exact completion edge.
  task automatic applyStimulus(input logic wide, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [31:0] expected, input string name);
    int lat;
    int waitCycles;
    lat = wide ? 16 : 8;
    waitCycles = 0;
    @(negedge clk);
    while (!(wide ? inReady16 : inReady8) && waitCycles < 64) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 64) begin
      checkOutput({name, " accept timeout"}, 32'd0, 32'd1);
      return;
    end
    if (wide) begin
      a16 = a[15:0]; b16 = b[15:0]; sgn16 = s; inValid16 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; sgn8 = s; inValid8 = 1'b1;
    end
    @(posedge clk);
    #1;
    inValid8 = 1'b0;
    inValid16 = 1'b0;
    checkOutput({name, " in_ready in RUN"}, {31'd0, (wide ? inReady16 : inReady8)}, 32'd0);
    checkOutput({name, " busy in RUN"}, {31'd0, (wide ? busy16 : busy8)}, 32'd1);
    repeat (lat - 1) @(posedge clk);
    #1;
    checkOutput({name, " out_valid early"}, {31'd0, (wide ? outValid16 : outValid8)}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, " out_valid"}, {31'd0, (wide ? outValid16 : outValid8)}, 32'd1);
    checkOutput({name, " product"}, wide ? prod16 : {16'd0, prod8}, expected);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'd98,      32'd115,     1'b0, 32'd11270,      "u 98*115"};
    vecs[1]  = '{1'b0, 32'd170,     32'd99,      1'b0, 32'd16830,      "u 170*99"};
    vecs[2]  = '{1'b0, 32'd229,     32'd42,      1'b0, 32'd9618,       "u 229*42"};
    vecs[3]  = '{1'b0, 32'hE5,      32'd42,      1'b1, 32'hFB92,       "s -27*42"};
    vecs[4]  = '{1'b0, 32'h80,      32'h80,      1'b1, 32'h4000,       "s -128*-128"};
    vecs[5]  = '{1'b0, 32'hFF,      32'hFF,      1'b0, 32'hFE01,       "u 255*255"};
    vecs[6]  = '{1'b0, 32'h80,      32'h01,      1'b1, 32'hFF80,       "s -128*1"};
    vecs[7]  = '{1'b0, 32'h00,      32'hC8,      1'b1, 32'h0000,       "s 0*-56"};
    vecs[8]  = '{1'b0, 32'hFF,      32'hFF,      1'b1, 32'h0001,       "s -1*-1"};
    vecs[9]  = '{1'b0, 32'h7F,      32'h80,      1'b1, 32'hC080,       "s 127*-128"};
    vecs[10] = '{1'b1, 32'hFFFF,    32'hFFFF,    1'b0, 32'hFFFE0001,   "u16 max*max"};
    vecs[11] = '{1'b1, 32'h8000,    32'h0001,    1'b1, 32'hFFFF8000,   "s16 min*1"};
    vecs[12] = '{1'b1, 32'hFFFF,    32'hFFFF,    1'b1, 32'h00000001,   "s16 -1*-1"};
    vecs[13] = '{1'b1, 32'h1234,    32'h0000,    1'b0, 32'h00000000,   "u16 x*0"};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {31'd0, inReady8}, 32'd1);
    checkOutput("reset out_valid", {31'd0, outValid8}, 32'd0);
    checkOutput("reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("reset product", {16'd0, prod8}, 32'd0);
    checkOutput("reset16 product", prod16, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].isSigned, vecs[i].expected, vecs[i].name);

    // Handoff edge returns to IDLE; in_ready must not rise before it.
    applyStimulus(1'b0, 32'd6, 32'd7, 1'b0, 32'd42, "b2b first");
    checkOutput("b2b in_ready at done", {31'd0, inReady8}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b out_valid after handoff", {31'd0, outValid8}, 32'd0);
    checkOutput("b2b in_ready after handoff", {31'd0, inReady8}, 32'd1);

    outReady8 = 1'b0;
    applyStimulus(1'b0, 32'd12, 32'd11, 1'b0, 32'd132, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a8 = 8'd50; b8 = 8'd3; inValid8 = 1'b1;
      end else begin
        inValid8 = 1'b0;
      end
      @(posedge clk);
      #1;
      checkOutput("bp out_valid held", {31'd0, outValid8}, 32'd1);
      checkOutput("bp product held", {16'd0, prod8}, 32'd132);
      checkOutput("bp in_ready low", {31'd0, inReady8}, 32'd0);
    end
    @(negedge clk);
    inValid8 = 1'b0;
    outReady8 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp handoff out_valid", {31'd0, outValid8}, 32'd0);
    checkOutput("bp handoff in_ready", {31'd0, inReady8}, 32'd1);
    checkOutput("bp handoff busy", {31'd0, busy8}, 32'd0);

    @(negedge clk);
    a8 = 8'd9; b8 = 8'd7; sgn8 = 1'b0; inValid8 = 1'b1;
    @(posedge clk);
    #1;
    inValid8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun reset in_ready", {31'd0, inReady8}, 32'd1);
    checkOutput("midrun reset out_valid", {31'd0, outValid8}, 32'd0);
    checkOutput("midrun reset busy", {31'd0, busy8}, 32'd0);
    checkOutput("midrun reset product", {16'd0, prod8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd3, 32'd5, 1'b0, 32'd15, "after reset 3*5");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
